// File: rtl/mult_arb.sv
// mult_arb: round-robin arbiter sharing one signed/unsigned multiplier
// among NREQ requesters, one operation in flight, valid/ready on both sides.
// Ports: clk, rst_n (async active-low),
//   req_valid_i/req_ready_o/req_a_i/req_b_i/req_tc_i per requester (flat vectors),
//   rsp_valid_o/rsp_ready_i/rsp_c_o/rsp_id_o for the single result channel.
// Option: define MULT_ARB_OUT_REG_EN to register the product (CALC state, 2-cycle latency).

package math_pkg;
    // Default multiplier implementation select for mult_bw.
    localparam bit MBE_IV = 1'b1;
endpackage

// mult_bw: ADw x BDw multiplier, tc=1 two's complement, tc=0 unsigned.
// Ports: a, b, tc in; c (AW+BW bits) out, full product.
module mult_bw
    import math_pkg::*;
#(
    parameter int AW  = 8,
    parameter int BW  = 8,
    parameter bit MBE = MBE_IV
) (
    input  logic [AW-1:0]    a,
    input  logic [BW-1:0]    b,
    input  logic             tc,
    output logic [AW+BW-1:0] c
);
    localparam int W = AW + BW;

    logic [W-1:0] ax;
    logic [W-1:0] bx;

    // Extending to the full product width makes the truncated product
    // correct for both signed and unsigned operands.
    always_comb begin
        ax = tc ? {{BW{a[AW-1]}}, a} : {{BW{1'b0}}, a};
        bx = tc ? {{AW{b[BW-1]}}, b} : {{AW{1'b0}}, b};
    end

    if (MBE) begin : g_native
        assign c = ax * bx;
    end else begin : g_shift_add
        always_comb begin
            c = '0;
            for (int i = 0; i < W; i++) begin
                if (bx[i]) c = c + (ax << i);
            end
        end
    end
endmodule

module mult_arb
    import math_pkg::*;
#(
    parameter int ADw  = 8,
    parameter int BDw  = 8,
    parameter int NREQ = 4,
    parameter bit MBE  = MBE_IV
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic [NREQ*ADw-1:0]       req_a_i,
    input  logic [NREQ*BDw-1:0]       req_b_i,
    input  logic [NREQ-1:0]           req_tc_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ADw+BDw-1:0]        rsp_c_o,
    output logic [$clog2(NREQ)-1:0]   rsp_id_o
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = ADw + BDw;

`ifdef MULT_ARB_OUT_REG_EN
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, RESP} state_t;
`endif

    state_t         state;
    state_t         state_nx;
    logic [IW-1:0]  last_grant;
    logic [IW-1:0]  gnt_idx;
    logic           gnt_any;
    logic           accept;
    logic [ADw-1:0] op_a;
    logic [BDw-1:0] op_b;
    logic           op_tc;
    logic [IW-1:0]  op_id;
    logic [CW-1:0]  mul_c;

    // Search starts just past the last winner and wraps around.
    always_comb begin : rr_search
        int j;
        gnt_any = 1'b0;
        gnt_idx = '0;
        j = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last_grant) + k) % NREQ;
            if (!gnt_any && req_valid_i[j[IW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = j[IW-1:0];
            end
        end
    end

    assign accept = (state == IDLE) && gnt_any && rst_n;

    // Gated by rst_n so no grant is visible while reset is held.
    assign req_ready_o = accept ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
`ifdef MULT_ARB_OUT_REG_EN
                if (accept) state_nx = CALC;
`else
                if (accept) state_nx = RESP;
`endif
            end
`ifdef MULT_ARB_OUT_REG_EN
            CALC: state_nx = RESP;
`endif
            RESP: if (rsp_ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= IW'(NREQ - 1);
            op_a       <= '0;
            op_b       <= '0;
            op_tc      <= 1'b0;
            op_id      <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                last_grant <= gnt_idx;
                op_a       <= req_a_i[gnt_idx*ADw +: ADw];
                op_b       <= req_b_i[gnt_idx*BDw +: BDw];
                op_tc      <= req_tc_i[gnt_idx];
                op_id      <= gnt_idx;
            end
        end
    end

    mult_bw #(
        .AW  (ADw),
        .BW  (BDw),
        .MBE (MBE)
    ) u_mul (
        .a  (op_a),
        .b  (op_b),
        .tc (op_tc),
        .c  (mul_c)
    );

`ifdef MULT_ARB_OUT_REG_EN
    logic [CW-1:0] res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (state == CALC) begin
            res_q <= mul_c;
        end
    end

    assign rsp_c_o = res_q;
`else
    // Operand registers hold through RESP, so the product is stable.
    assign rsp_c_o = mul_c;
`endif

    assign rsp_valid_o = (state == RESP);
    assign rsp_id_o    = op_id;
endmodule

// File: doc/mult_arb.md
MULT_ARB -- requirements
Module: mult_arb

Interface
REQ-001 The module SHALL declare parameter ADw, default 8, meaning multiplicand A width in bits.
REQ-002 The module SHALL declare parameter BDw, default 8, meaning multiplier B width in bits.
REQ-003 The module SHALL declare parameter NREQ, default 4, meaning number of requesters (2..16).
REQ-004 The module SHALL declare parameter MBE, default MBE_IV from math_pkg, meaning Booth encoding passed unchanged to the internal mult_bw.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all flops SHALL update on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The module SHALL have port req_valid_i, input, NREQ bits: per-requester operation valid.
REQ-008 The module SHALL have port req_ready_o, output, NREQ bits: per-requester accept.
REQ-009 The module SHALL have port req_a_i, input, NREQ x ADw bits: per-requester operand A.
REQ-010 The module SHALL have port req_b_i, input, NREQ x BDw bits: per-requester operand B.
REQ-011 The module SHALL have port req_tc_i, input, NREQ bits: per-requester mode, 1 = two's complement, 0 = unsigned.
REQ-012 The module SHALL have port rsp_valid_o, output, 1 bit: result valid.
REQ-013 The module SHALL have port rsp_ready_i, input, 1 bit: result consumer ready.
REQ-014 The module SHALL have port rsp_c_o, output, ADw+BDw bits: product.
REQ-015 The module SHALL have port rsp_id_o, output, $clog2(NREQ) bits: index of the requester that owns the product.

Function
REQ-016 The module SHALL share one mult_bw instance among all requesters and SHALL allow at most one operation in flight.
REQ-017 The FSM SHALL have states IDLE, CALC (present only with the macro in REQ-028) and RESP.
REQ-018 In IDLE, req_ready_o SHALL be one-hot on the round-robin winner among asserted req_valid_i bits; it SHALL be all-zero in every other state and when no request is valid.
REQ-019 Round-robin SHALL search from index last_grant+1 upward, wrapping from NREQ-1 to 0; last_grant SHALL update only on an accepted handshake (valid & ready).
REQ-020 On accept, the module SHALL capture a, b, tc and id into operand registers that drive mult_bw, and SHALL leave IDLE.
REQ-021 rsp_valid_o SHALL be high exactly in RESP; rsp_c_o and rsp_id_o SHALL be stable while rsp_valid_o is high and rsp_ready_i is low.
REQ-022 In RESP with rsp_ready_i high, the FSM SHALL return to IDLE; a new grant SHALL NOT occur in that same cycle, so the minimum per-operation issue interval is latency+1 cycles.
REQ-023 rsp_c_o SHALL equal signed(a)*signed(b) when tc = 1 and unsigned(a)*unsigned(b) when tc = 0, truncated to ADw+BDw bits (full product, no overflow).
REQ-024 A requester dropping req_valid_i while not granted SHALL lose nothing; req_valid_i SHALL NOT be required to stay high after its accept.

Reset
REQ-025 While rst_n is low the FSM SHALL be IDLE, last_grant SHALL be NREQ-1 (so index 0 wins first), and operand and result registers SHALL be 0.
REQ-026 During reset, rsp_valid_o SHALL be 0, rsp_c_o SHALL be 0, rsp_id_o SHALL be 0 and req_ready_o SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard the operation with no response issued; after reset release, operation SHALL start from the REQ-025 state.

Configuration
REQ-028 With macro MULT_ARB_OUT_REG_EN defined, accept SHALL go to CALC, which SHALL register the mult_bw product and proceed to RESP; the latency from accept edge to rsp_valid_o high SHALL be 2 cycles.
REQ-029 Without MULT_ARB_OUT_REG_EN, accept SHALL go directly to RESP with rsp_c_o driven combinationally from the mult_bw output on the operand registers; the latency SHALL be 1 cycle.

Verification
REQ-030 Single requester 0, a=8'hFF, b=8'h02, tc=1, rsp_ready_i=1 -> rsp_c_o=16'hFFFE, rsp_id_o=0, rsp_valid_o high 1 cycle (2 cycles with macro) after accept.
REQ-031 Same operands with tc=0 -> rsp_c_o=16'h01FE.
REQ-032 All four requesters valid continuously after reset -> grant order 0,1,2,3,0; each rsp_id_o matches its operands' product.
REQ-033 rsp_ready_i held low 5 cycles in RESP -> rsp_valid_o, rsp_c_o and rsp_id_o stable, req_ready_o all zero; one cycle after ready rises, a new grant is issued.
REQ-034 rst_n pulsed low while in RESP (or CALC) -> all outputs 0 immediately, no response after release, next grant goes to index 0.
REQ-035 Exhaustive sweep of 2^16 (a,b) pairs per mode through requester 2 -> every rsp_c_o matches the golden signed/unsigned product in both macro builds.
